// File: rtl/booth_radix4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per cycle, valid/ready on both sides.
// Handles signed and unsigned operands; operands are widened by two bits so both modes share one datapath.
module booth_radix4_seq_mult #(
  parameter int WIDTH     = 24,
  parameter int TAG_WIDTH = 1
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   In_Valid_SI,
  output logic                   In_Ready_SO,
  input  logic [WIDTH-1:0]       Op_A_DI,
  input  logic [WIDTH-1:0]       Op_B_DI,
  input  logic                   Signed_SI,
  input  logic [TAG_WIDTH-1:0]   Tag_DI,
  input  logic                   Flush_SI,
  output logic                   Out_Valid_SO,
  input  logic                   Out_Ready_SI,
  output logic [2*WIDTH-1:0]     Result_DO,
  output logic [TAG_WIDTH-1:0]   Tag_DO
);

  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [E-1:0]           a_r;
  logic [E-1:0]           b_r;
  logic                   signed_r;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic [PW-1:0]          acc_r;
  logic [CW-1:0]          cnt_r;
  logic [PW-1:0]          result_r;
  logic [TAG_WIDTH-1:0]   tag_out_r;

  logic                   accept_s;
  logic [E-1:0]           a_ext_s;
  logic [E-1:0]           b_ext_s;
  logic [E:0]             b_pad_s;
  logic [E:0]             b_sh_s;
  logic [CW:0]            shamt_s;
  logic [2:0]             sel_s;
  logic                   sel_1x_s;
  logic                   sel_2x_s;
  logic                   sel_neg_s;
  logic [PW-1:0]          a_wide_s;
  logic [PW-1:0]          pp_mag_s;
  logic [PW-1:0]          pp_s;
  logic [PW-1:0]          cin_s;
  logic [PW-1:0]          acc_next_s;

  // Booth recode of {b[2i+1], b[2i], b[2i-1]} into {sel_1x, sel_2x, sel_neg}.
  function automatic logic [2:0] booth_sel(input logic [2:0] triple);
    case (triple)
      3'b001, 3'b010: booth_sel = 3'b100;
      3'b011:         booth_sel = 3'b010;
      3'b100:         booth_sel = 3'b011;
      3'b101, 3'b110: booth_sel = 3'b101;
      default:        booth_sel = 3'b000;
    endcase
  endfunction

  // Handshake decode; a flush cycle never accepts.
  always_comb begin
    In_Ready_SO  = 1'b0;
    Out_Valid_SO = 1'b0;
    if (Flush_SI) begin
      In_Ready_SO = 1'b0;
    end else if (state_r == IDLE) begin
      In_Ready_SO = 1'b1;
    end else if (state_r == DONE) begin
      In_Ready_SO = Out_Ready_SI;
    end else begin
      In_Ready_SO = 1'b0;
    end
    Out_Valid_SO = (state_r == DONE);
  end

  assign accept_s  = In_Valid_SI & In_Ready_SO;
  assign Result_DO = result_r;
  assign Tag_DO    = tag_out_r;

  // Operand widening, digit selection and one accumulation step.
  always_comb begin
    if (Signed_SI) begin
      a_ext_s = {{2{Op_A_DI[WIDTH-1]}}, Op_A_DI};
      b_ext_s = {{2{Op_B_DI[WIDTH-1]}}, Op_B_DI};
    end else begin
      a_ext_s = {2'b00, Op_A_DI};
      b_ext_s = {2'b00, Op_B_DI};
    end
    shamt_s   = {cnt_r, 1'b0};
    b_pad_s   = {b_r, 1'b0};
    b_sh_s    = b_pad_s >> shamt_s;
    sel_s     = booth_sel(b_sh_s[2:0]);
    sel_1x_s  = sel_s[2];
    sel_2x_s  = sel_s[1];
    sel_neg_s = sel_s[0];
    a_wide_s  = {{(PW-E){signed_r & a_r[E-1]}}, a_r};
    if (sel_1x_s) begin
      pp_mag_s = a_wide_s;
    end else if (sel_2x_s) begin
      pp_mag_s = a_wide_s << 1;
    end else begin
      pp_mag_s = '0;
    end
    // Negation is ~pp plus a +1 injected at the digit's own weight.
    if (sel_neg_s) begin
      pp_s  = ~pp_mag_s;
      cin_s = PW'(1) << shamt_s;
    end else begin
      pp_s  = pp_mag_s;
      cin_s = '0;
    end
    acc_next_s = acc_r + (pp_s << shamt_s) + cin_s;
  end

  // Control FSM with operand, accumulator and result registers.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      signed_r  <= 1'b0;
      tag_r     <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      result_r  <= '0;
      tag_out_r <= '0;
    end else if (Flush_SI) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            a_r      <= a_ext_s;
            b_r      <= b_ext_s;
            signed_r <= Signed_SI;
            tag_r    <= Tag_DI;
            acc_r    <= '0;
            cnt_r    <= '0;
            state_r  <= BUSY;
          end else if (state_r == DONE && Out_Ready_SI) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        BUSY: begin
          acc_r <= acc_next_s;
          if (cnt_r == LAST_CNT) begin
            result_r  <= acc_next_s;
            tag_out_r <= tag_r;
            cnt_r     <= '0;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Scoreboard bench for booth_radix4_seq_mult: stimulus pushes expected products, a monitor pops
// and compares on every result handshake.
module tb_booth_radix4_seq_mult;

  localparam int W  = 24;
  localparam int TW = 1;
  localparam int N  = 13;
  localparam int PW = 2 * W;

  logic            Clk_CI = 1'b0;
  logic            Rst_RBI = 1'b1;
  logic            In_Valid_SI = 1'b0;
  logic            In_Ready_SO;
  logic [W-1:0]    Op_A_DI = '0;
  logic [W-1:0]    Op_B_DI = '0;
  logic            Signed_SI = 1'b0;
  logic [TW-1:0]   Tag_DI = '0;
  logic            Flush_SI = 1'b0;
  logic            Out_Valid_SO;
  logic            Out_Ready_SI;
  logic [PW-1:0]   Result_DO;
  logic [TW-1:0]   Tag_DO;

  booth_radix4_seq_mult #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .In_Valid_SI(In_Valid_SI), .In_Ready_SO(In_Ready_SO),
    .Op_A_DI(Op_A_DI), .Op_B_DI(Op_B_DI), .Signed_SI(Signed_SI), .Tag_DI(Tag_DI),
    .Flush_SI(Flush_SI),
    .Out_Valid_SO(Out_Valid_SO), .Out_Ready_SI(Out_Ready_SI),
    .Result_DO(Result_DO), .Tag_DO(Tag_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic [PW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          s;
    logic [TW-1:0] tag;
    logic [PW-1:0] res;
  } vec_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic rand_bp = 1'b0;
  logic ready_req = 1'b1;

  vec_t vecs[10] = '{
    '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 48'hFFFFFE000001},
    '{24'hFFFFFD, 24'h000005, 1'b1, 1'b1, 48'hFFFFFFFFFFF1},
    '{24'h800000, 24'h800000, 1'b1, 1'b0, 48'h400000000000},
    '{24'h000000, 24'h7FFFFF, 1'b1, 1'b1, 48'h000000000000},
    '{24'h000003, 24'h000007, 1'b0, 1'b0, 48'h000000000015},
    '{24'h7FFFFF, 24'h800000, 1'b1, 1'b1, 48'hC00000800000},
    '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 48'h000000000001},
    '{24'h123456, 24'h000010, 1'b0, 1'b1, 48'h000001234560},
    '{24'h800000, 24'h800000, 1'b0, 1'b1, 48'h400000000000},
    '{24'hFFFFFF, 24'h000002, 1'b1, 1'b0, 48'hFFFFFFFFFFFE}
  };

  always @(posedge Clk_CI) cyc <= cyc + 1;

  // Consumer-side ready: either the requested level or random backpressure.
  initial begin
    Out_Ready_SI = 1'b1;
    forever begin
      @(posedge Clk_CI);
      #2;
      Out_Ready_SI = rand_bp ? ($urandom_range(0, 3) != 0) : ready_req;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ax * bx;
  endfunction

  // Monitor: every result handshake must match the oldest outstanding expectation.
  always @(negedge Clk_CI) begin
    if (Rst_RBI && Out_Valid_SO && Out_Ready_SI && !Flush_SI) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got 0x%0h with no pending operation", Result_DO);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {16'd0, Result_DO}, {16'd0, e.res});
        check("tag", {63'd0, Tag_DO}, {63'd0, e.tag});
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] t, input logic [PW-1:0] res);
    int n;
    exp_t e;
    @(posedge Clk_CI);
    #1;
    In_Valid_SI = 1'b1;
    Op_A_DI = a;
    Op_B_DI = b;
    Signed_SI = s;
    Tag_DI = t;
    n = 0;
    @(negedge Clk_CI);
    while (!In_Ready_SO && n < 300) begin
      @(negedge Clk_CI);
      n++;
    end
    if (n >= 300) begin
      total_cnt++;
      $display("FAIL accept_timeout: waited %0d cycles, required fewer than 300", n);
    end
    e.res = res;
    e.tag = t;
    sb_q.push_back(e);
    @(posedge Clk_CI);
    #1;
    acc_cyc = cyc;
    In_Valid_SI = 1'b0;
    Op_A_DI = W'($urandom);
    Op_B_DI = W'($urandom);
    Signed_SI = ~s;
    Tag_DI = ~t;
  endtask

  task automatic wait_valid(input logic chk_lat);
    int n;
    n = 0;
    @(negedge Clk_CI);
    while (!Out_Valid_SO && n < 100) begin
      @(negedge Clk_CI);
      n++;
    end
    if (n >= 100) begin
      total_cnt++;
      $display("FAIL valid_timeout: waited %0d cycles, required fewer than 100", n);
    end else if (chk_lat) begin
      check("latency", 64'(cyc - acc_cyc), 64'(N));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    // Reset state.
    #1;
    Rst_RBI = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, In_Ready_SO}, 64'd1);
    check("rst_out_valid", {63'd0, Out_Valid_SO}, 64'd0);
    check("rst_result", {16'd0, Result_DO}, 64'd0);
    check("rst_tag", {63'd0, Tag_DO}, 64'd0);
    repeat (3) @(negedge Clk_CI);
    Rst_RBI = 1'b1;

    // Directed products with latency check.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag, vecs[i].res);
      wait_valid(1'b1);
    end

    // Backpressure: result held for 5 cycles, then same-cycle accept on release.
    ready_req = 1'b0;
    send(24'h000100, 24'h000200, 1'b0, 1'b0, 48'h000000020000);
    wait_valid(1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk_CI);
      check("bp_result", {16'd0, Result_DO}, 64'h20000);
      check("bp_tag", {63'd0, Tag_DO}, 64'd0);
      check("bp_in_ready", {63'd0, In_Ready_SO}, 64'd0);
      check("bp_valid", {63'd0, Out_Valid_SO}, 64'd1);
    end
    ready_req = 1'b1;
    send(24'hFFFFFD, 24'h000005, 1'b1, 1'b1, 48'hFFFFFFFFFFF1);
    wait_valid(1'b1);

    // Flush in BUSY cycle 6.
    send(24'h0FFFFF, 24'h000003, 1'b0, 1'b1, 48'h000002FFFFD);
    repeat (6) @(posedge Clk_CI);
    #1;
    Flush_SI = 1'b1;
    @(posedge Clk_CI);
    #1;
    Flush_SI = 1'b0;
    void'(sb_q.pop_back());
    @(negedge Clk_CI);
    check("flush_idle_valid", {63'd0, Out_Valid_SO}, 64'd0);
    check("flush_idle_ready", {63'd0, In_Ready_SO}, 64'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk_CI);
      if (Out_Valid_SO) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    send(24'h000100, 24'h000100, 1'b0, 1'b1, 48'h000000010000);
    wait_valid(1'b1);

    // Asynchronous reset mid-BUSY.
    send(24'h000ABC, 24'h000123, 1'b0, 1'b1, 48'h0000000C33B4);
    repeat (4) @(posedge Clk_CI);
    #3;
    Rst_RBI = 1'b0;
    #1;
    check("arst_in_ready", {63'd0, In_Ready_SO}, 64'd1);
    check("arst_out_valid", {63'd0, Out_Valid_SO}, 64'd0);
    check("arst_result", {16'd0, Result_DO}, 64'd0);
    check("arst_tag", {63'd0, Tag_DO}, 64'd0);
    void'(sb_q.pop_back());
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    send(24'h000003, 24'h000007, 1'b0, 1'b0, 48'h000000000015);
    wait_valid(1'b1);

    // Random sweep with backpressure and occasional flush during BUSY.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, TW'(i), model(ra, rb, rs));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, N - 2)) @(posedge Clk_CI);
        #1;
        Flush_SI = 1'b1;
        @(posedge Clk_CI);
        #1;
        Flush_SI = 1'b0;
        void'(sb_q.pop_back());
      end
    end
    rand_bp = 1'b0;
    ready_req = 1'b1;
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge Clk_CI);
    check("drain", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
